// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pkg
// Purpose  : Shared pipeline definitions: fetch FSM state encoding, the NOP
//            instruction word and the default reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] C_NOP              = 32'h0000_0000;
  localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Purpose  : Bundles the fetch stage's hazard/redirect inputs, the
//            instruction-memory handshake and the IF/ID register outputs.
// Modports : master - the fetch stage itself
//            slave  - decode stage / instruction memory side
// Revision : 1.0 - initial release
// ============================================================================
interface if_stage_if;
  logic        PCWriteEnable;
  logic        IFIDWriteEnable;
  logic        IFIDFlush;
  logic        Branch;
  logic        Jump;
  logic [31:0] BranchDest;
  logic [31:0] JumpDest;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Instruction_Out;
  logic [31:0] PC_Out;
  logic        Valid_Out;
  logic        FetchStall_Out;

  modport master (
    input  PCWriteEnable, IFIDWriteEnable, IFIDFlush, Branch, Jump,
    input  BranchDest, JumpDest, IMemReady, IMemData,
    output IMemReq, IMemAddr, Instruction_Out, PC_Out, Valid_Out,
    output FetchStall_Out
  );

  modport slave (
    output PCWriteEnable, IFIDWriteEnable, IFIDFlush, Branch, Jump,
    output BranchDest, JumpDest, IMemReady, IMemData,
    input  IMemReq, IMemAddr, Instruction_Out, PC_Out, Valid_Out,
    input  FetchStall_Out
  );
endinterface : if_stage_if
`default_nettype wire

// File: rtl/if_stage_ifid_register.sv
`default_nettype none
// ============================================================================
// Module   : ifid_register
// Purpose  : Pipeline register holding instruction, PC and valid bit.
//            Priority: flush (bubble) > hold > load > bubble.
// Ports    : clk, rst (async, active-high)
//            i_flush, i_write_en, i_load, i_instr, i_pc
//            o_instr, o_pc, o_valid
// Revision : 1.0 - initial release
// ============================================================================
module ifid_register
  import if_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_flush,
  input  wire logic              i_write_en,
  input  wire logic              i_load,
  input  wire logic [DATA_W-1:0] i_instr,
  input  wire logic [DATA_W-1:0] i_pc,
  output logic      [DATA_W-1:0] o_instr,
  output logic      [DATA_W-1:0] o_pc,
  output logic                   o_valid
);

  localparam logic [DATA_W-1:0] C_BUBBLE_INSTR = DATA_W'(C_NOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_instr <= C_BUBBLE_INSTR;
      o_pc    <= '0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_instr <= C_BUBBLE_INSTR;
      o_pc    <= '0;
      o_valid <= 1'b0;
    end else if (!i_write_en) begin
      o_instr <= o_instr;
      o_pc    <= o_pc;
      o_valid <= o_valid;
    end else if (i_load) begin
      o_instr <= i_instr;
      o_pc    <= i_pc;
      o_valid <= 1'b1;
    end else begin
      // Stall, drain or redirect cycle: nothing usable, insert a bubble.
      o_instr <= C_BUBBLE_INSTR;
      o_pc    <= '0;
      o_valid <= 1'b0;
    end
  end

endmodule : ifid_register
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : MIPS instruction-fetch stage. Owns the PC, the pending-redirect
//            register and the IDLE/FETCH/DRAIN fetch FSM that drives a
//            variable-latency instruction-memory request/ready handshake,
//            and feeds the IF/ID pipeline register.
// Ports    : clk, rst (async, active-high)
//            bus (if_stage_if.master): hazard/redirect inputs, IMem
//            handshake, IF/ID outputs and fetch-stall flag
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
  input wire logic  clk,
  input wire logic  rst,
  if_stage_if.master bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_pending;
  logic [31:0]  w_pending_next;

  logic         w_req;
  logic         w_accept;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_load;

  // Request and address depend only on registered state, never on the
  // decode-stage inputs; in DRAIN the PC is untouched, so the outstanding
  // address stays stable until the memory accepts it.
  assign w_req              = (r_state != S_IDLE);
  assign bus.IMemReq        = w_req;
  assign bus.IMemAddr       = r_pc;
  assign bus.FetchStall_Out = w_req && !bus.IMemReady;

  assign w_accept   = w_req && bus.IMemReady;
  assign w_redirect = bus.Branch || bus.Jump;
  assign w_target   = (bus.Jump ? bus.JumpDest : bus.BranchDest) & 32'hFFFF_FFFC;

  // Only a plain accepted fetch produces a real instruction.
  assign w_load = (r_state == S_FETCH) && w_accept && !w_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_pending <= w_pending_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_pending_next = r_pending;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_redirect) begin
          if (w_accept) begin
            w_pc_next = w_target;
          end else begin
            // Cannot retarget mid-request: remember it and finish the
            // outstanding transfer first.
            w_pending_next = w_target;
            w_state_next   = S_DRAIN;
          end
        end else if (w_accept && bus.PCWriteEnable) begin
          w_pc_next = r_pc + 32'd4;
        end
      end
      S_DRAIN: begin
        if (w_redirect) begin
          w_pending_next = w_target;
        end
        if (w_accept) begin
          w_pc_next    = w_redirect ? w_target : r_pending;
          w_state_next = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  ifid_register #(
    .DATA_W (32)
  ) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (bus.IFIDFlush),
    .i_write_en (bus.IFIDWriteEnable),
    .i_load     (w_load),
    .i_instr    (bus.IMemData),
    .i_pc       (r_pc),
    .o_instr    (bus.Instruction_Out),
    .o_pc       (bus.PC_Out),
    .o_valid    (bus.Valid_Out)
  );

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: directed scenarios with
//            literal expectations plus randomized stimulus compared every
//            cycle against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  always_comb bus.IMemData = mem_word(bus.IMemAddr);

  // ---------------- behavioural model ----------------
  logic        m_active;    // a request is being issued (not the post-reset idle cycle)
  logic        m_draining;  // waiting out a request whose word is discarded
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  logic        m_valid;

  always @(posedge clk or posedge rst) begin
    logic        acc;
    logic        redir;
    logic        real_word;
    logic [31:0] tgt;
    if (rst) begin
      m_active   = 1'b0;
      m_draining = 1'b0;
      m_pc       = 32'h0;
      m_pend     = 32'h0;
      m_instr    = 32'h0;
      m_pcout    = 32'h0;
      m_valid    = 1'b0;
    end else begin
      acc       = m_active && bus.IMemReady;
      redir     = bus.Branch || bus.Jump;
      tgt       = {(bus.Jump ? bus.JumpDest[31:2] : bus.BranchDest[31:2]), 2'b00};
      real_word = acc && !m_draining && !redir;
      if (bus.IFIDFlush) begin
        m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
      end else if (bus.IFIDWriteEnable) begin
        if (real_word) begin
          m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1;
        end else begin
          m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
        end
      end
      if (!m_active) begin
        m_active = 1'b1;
      end else if (m_draining) begin
        if (redir) m_pend = tgt;
        if (acc) begin
          m_pc       = m_pend;
          m_draining = 1'b0;
        end
      end else if (redir) begin
        if (acc) m_pc = tgt;
        else begin
          m_pend     = tgt;
          m_draining = 1'b1;
        end
      end else if (acc && bus.PCWriteEnable) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic        e_stall;
    e_stall = m_active && !bus.IMemReady;
    n_tests++;
    if (bus.IMemReq !== m_active || bus.IMemAddr !== m_pc ||
        bus.FetchStall_Out !== e_stall || bus.Instruction_Out !== m_instr ||
        bus.PC_Out !== m_pcout || bus.Valid_Out !== m_valid) begin
      n_fail++;
      $display("FAIL cycle %0d: got req=%b addr=%h stall=%b instr=%h pc=%h v=%b, expected req=%b addr=%h stall=%b instr=%h pc=%h v=%b",
               cyc, bus.IMemReq, bus.IMemAddr, bus.FetchStall_Out, bus.Instruction_Out,
               bus.PC_Out, bus.Valid_Out, m_active, m_pc, e_stall, m_instr, m_pcout, m_valid);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    bus.IMemReady       = 1'b1;
    bus.Branch          = 1'b0;
    bus.Jump            = 1'b0;
    bus.BranchDest      = 32'h0;
    bus.JumpDest        = 32'h0;
    bus.PCWriteEnable   = 1'b1;
    bus.IFIDWriteEnable = 1'b1;
    bus.IFIDFlush       = 1'b0;
  endtask

  task automatic do_jump(input logic [31:0] dest);
    bus.Jump     = 1'b1;
    bus.JumpDest = dest;
    tick();
    bus.Jump     = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst     = 1'b0;
    set_defaults();

    fork
      forever begin
        @(negedge clk);
        cyc++;
        compare_cycle();
      end
    join_none

    #1 rst = 1'b1;
    #1;
    check_lit("reset_req",   {31'h0, bus.IMemReq}, 32'h0);
    check_lit("reset_addr",  bus.IMemAddr, 32'h0);
    check_lit("reset_valid", {31'h0, bus.Valid_Out}, 32'h0);
    check_lit("reset_instr", bus.Instruction_Out, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Idle cycle, then sequential zero-wait fetch.
    check_lit("idle_req", {31'h0, bus.IMemReq}, 32'h0);
    tick();
    check_lit("first_req",  {31'h0, bus.IMemReq}, 32'h1);
    check_lit("first_addr", bus.IMemAddr, 32'h0);
    tick();
    check_lit("seq_addr4", bus.IMemAddr, 32'h4);
    check_lit("seq_pc0",   bus.PC_Out, 32'h0);
    tick();
    check_lit("seq_addr8", bus.IMemAddr, 32'h8);
    check_lit("seq_pc4",   bus.PC_Out, 32'h4);
    check_lit("seq_instr4", bus.Instruction_Out, mem_word(32'h4));
    check_lit("seq_valid", {31'h0, bus.Valid_Out}, 32'h1);

    // Memory wait of 3 cycles at 0x10.
    guard = 0;
    while (bus.IMemAddr != 32'h10 && guard < 20) begin
      tick();
      guard++;
    end
    check_lit("reach_0x10", bus.IMemAddr, 32'h10);
    bus.IMemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_lit("wait_addr",  bus.IMemAddr, 32'h10);
      check_lit("wait_stall", {31'h0, bus.FetchStall_Out}, 32'h1);
      check_lit("wait_valid", {31'h0, bus.Valid_Out}, 32'h0);
    end
    bus.IMemReady = 1'b1;
    tick();
    check_lit("after_wait_pc",    bus.PC_Out, 32'h10);
    check_lit("after_wait_valid", {31'h0, bus.Valid_Out}, 32'h1);
    check_lit("after_wait_instr", bus.Instruction_Out, mem_word(32'h10));

    // Jump with accept: target fetched next, jump-cycle word never valid.
    do_jump(32'h400);
    check_lit("jump_addr",  bus.IMemAddr, 32'h400);
    check_lit("jump_valid", {31'h0, bus.Valid_Out}, 32'h0);
    tick();
    check_lit("jump_tgt_pc", bus.PC_Out, 32'h400);

    // Branch during a memory wait at 0x20 (low bits of dest ignored).
    do_jump(32'h20);
    bus.IMemReady  = 1'b0;
    bus.Branch     = 1'b1;
    bus.BranchDest = 32'h83;
    tick();
    bus.Branch = 1'b0;
    check_lit("drain_addr", bus.IMemAddr, 32'h20);
    tick();
    check_lit("drain_addr2", bus.IMemAddr, 32'h20);
    bus.IMemReady = 1'b1;
    tick();
    check_lit("drain_tgt",   bus.IMemAddr, 32'h80);
    check_lit("drain_valid", {31'h0, bus.Valid_Out}, 32'h0);

    // Hold PC and IF/ID for two cycles at 0x30.
    do_jump(32'h2C);
    tick();
    check_lit("hold_addr_pre", bus.IMemAddr, 32'h30);
    bus.PCWriteEnable   = 1'b0;
    bus.IFIDWriteEnable = 1'b0;
    tick();
    tick();
    check_lit("hold_addr", bus.IMemAddr, 32'h30);
    check_lit("hold_pc",   bus.PC_Out, 32'h2C);
    check_lit("hold_valid", {31'h0, bus.Valid_Out}, 32'h1);
    bus.PCWriteEnable   = 1'b1;
    bus.IFIDWriteEnable = 1'b1;
    tick();
    check_lit("hold_next_pc", bus.PC_Out, 32'h30);
    check_lit("hold_next_addr", bus.IMemAddr, 32'h34);

    // PC wrap-around.
    do_jump(32'hFFFF_FFFC);
    check_lit("wrap_pre", bus.IMemAddr, 32'hFFFF_FFFC);
    tick();
    check_lit("wrap_addr", bus.IMemAddr, 32'h0);
    check_lit("wrap_pc",   bus.PC_Out, 32'hFFFF_FFFC);

    // Reset asserted while draining.
    bus.IMemReady  = 1'b0;
    bus.Branch     = 1'b1;
    bus.BranchDest = 32'h100;
    tick();
    bus.Branch = 1'b0;
    rst = 1'b1;
    #1;
    check_lit("rst_drain_req",   {31'h0, bus.IMemReq}, 32'h0);
    check_lit("rst_drain_addr",  bus.IMemAddr, 32'h0);
    check_lit("rst_drain_stall", {31'h0, bus.FetchStall_Out}, 32'h0);
    tick();
    rst = 1'b0;
    bus.IMemReady = 1'b1;
    tick();
    tick();
    check_lit("rst_restart_addr", bus.IMemAddr, 32'h4);

    // Randomized traffic checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      bus.IMemReady       = ($urandom_range(0, 9) < 7);
      bus.Branch          = ($urandom_range(0, 9) == 0);
      bus.Jump            = ($urandom_range(0, 19) == 0);
      bus.BranchDest      = $urandom();
      bus.JumpDest        = $urandom();
      bus.PCWriteEnable   = ($urandom_range(0, 9) < 8);
      bus.IFIDWriteEnable = ($urandom_range(0, 9) < 8);
      bus.IFIDFlush       = ($urandom_range(0, 19) == 0);
      rst                 = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    set_defaults();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Produces the IF/ID pipeline register (instruction word, its PC, valid bit) consumed by the decode stage. It obeys the decode stage's hazard and redirect outputs: PC write enable, IF/ID write enable, IF/ID flush, branch/jump and their destinations. It drives a variable-latency instruction-memory request/ready handshake through a 3-state fetch FSM.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- PCWriteEnable  in  1  from hazard unit; 0 = hold PC
- IFIDWriteEnable  in  1  0 = hold IF/ID register
- IFIDFlush  in  1  1 = load bubble into IF/ID
- Branch, Jump  in  1 each  redirect request; Jump has priority
- BranchDest, JumpDest  in  32  redirect targets; bits [1:0] ignored (forced 0)
- IMemReq  out  1  fetch request
- IMemAddr  out  32  fetch address (word aligned)
- IMemReady  in  1  data valid / request accepted this cycle
- IMemData  in  32  instruction word, valid when IMemReady
- Instruction_Out  out  32  IF/ID instruction
- PC_Out  out  32  address of Instruction_Out
- Valid_Out  out  1  0 = bubble
- FetchStall_Out  out  1  high while IMemReq && !IMemReady

## Operation
- Accept = IMemReq && IMemReady. Redirect = Branch || Jump; target = Jump ? JumpDest : BranchDest, with [1:0] cleared.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: entered on reset. IMemReq=0. Next state is FETCH, unconditionally.
  - FETCH: IMemReq=1, IMemAddr=PC.
    - Redirect with Accept: PC<=target; stay in FETCH.
    - Redirect without Accept: Pending<=target; go to DRAIN. PC is unchanged and the address is held stable.
    - No redirect, Accept, PCWriteEnable=1: PC<=PC+4 (wraps mod 2^32).
    - Otherwise: PC is held.
  - DRAIN: IMemReq=1 with the old address.
    - A new redirect overwrites Pending (newest wins).
    - On Accept: the data is discarded, PC<=Pending (or the current-cycle target if a redirect is also present), and the FSM returns to FETCH.
- IMemAddr never changes while IMemReq && !IMemReady.
- Redirect is applied regardless of PCWriteEnable.
- IF/ID update priority:
  1. IFIDFlush: Instruction=32'h0 (nop), PC_Out=0, Valid=0.
  2. IFIDWriteEnable=0: hold all three.
  3. Accept in FETCH with no redirect: load IMemData, IMemAddr, and Valid=1.
  4. Otherwise (memory stall, DRAIN, IDLE, redirect-cycle word): bubble.
- A word accepted while IFIDWriteEnable=0 is dropped. PC is held by PCWriteEnable=0, so the same address is refetched.
- Reset values: PC=RESET_PC, Pending=0, state=IDLE, IMemReq=0, IMemAddr=RESET_PC, Instruction_Out=0, PC_Out=0, Valid_Out=0, FetchStall_Out=0.
- Reset mid-request aborts the request. The memory must tolerate IMemReq dropping.

## Timing
- Zero-wait memory (IMemReady=1 in the request cycle) sustains 1 instruction/cycle. The word appears on Instruction_Out the cycle after Accept.
- First request is issued in the 2nd cycle after Reset falls, because of IDLE.
- Redirect with zero-wait memory: the target is fetched in the next cycle, giving 1 bubble. The decode stage flushes the IF/ID slot of the redirecting cycle.
- Redirect during an N-cycle memory wait: the target fetch starts the cycle after the outstanding Accept.
- IMemReq, IMemAddr and FetchStall_Out are decoded from registered state and PC only, with no combinational path from the ID inputs.

## Structure
- Shared pipeline package holds:
  - FSM state encoding (IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2)
  - NOP constant 32'h0
  - default RESET_PC
- Sub-module ifid_register holds Instruction/PC/Valid with flush-over-hold-over-load priority. It is reusable for the other pipeline registers.
- PC register, Pending register and FSM stay in the top level.

## Test plan
- Reset, zero-wait memory:
  - IMemReq is 0 for one cycle after Reset falls.
  - Addresses then run 0,4,8,…
  - PC_Out/Instruction_Out follow one cycle behind with Valid=1.
- IMemReady low 3 cycles at addr 0x10:
  - IMemAddr stays 0x10 with FetchStall_Out=1.
  - Three bubbles (Valid=0) appear, then 0x10's word.
- Jump=1, JumpDest=0x400 with Accept:
  - Next IMemAddr=0x400.
  - The word fetched in the jump cycle never appears on Valid.
- Branch=1, BranchDest=0x80 while waiting at 0x20:
  - State goes to DRAIN and the address stays 0x20.
  - On Ready the word is discarded and the next IMemAddr=0x80.
- PCWriteEnable=0 with IFIDWriteEnable=0 for 2 cycles at 0x30:
  - IF/ID contents are held.
  - 0x30 is refetched.
  - No instruction is lost or duplicated on Valid.
- Reset asserted during DRAIN:
  - IMemReq drops immediately.
  - All outputs go to reset values and PC=RESET_PC.
- PC=0xFFFF_FFFC, Accept: next PC=0x0000_0000.
